// File: rtl/unidad_fetch.sv
// ---------------------------------------------------------------------------
// unidad_fetch
//
// Instruction fetch stage in front of a byte-wide, combinational instruction
// memory. It owns the 7-bit program counter, which it drives straight out as
// the memory address. The four returned bytes are captured into a registered
// 32-bit word and offered to decode over a valid/ready handshake. The stage
// also handles branch redirects (which flush the held word) and a halt
// opcode (32'hFFFF_FFFF).
//
// Optional feature macro: FETCH_ALINEACION_EN
//   defined   : a branch to a target with dest_salto[1:0] != 0 halts the
//               stage and raises the sticky err_alineacion flag.
//   undefined : branch targets are forced word-aligned (low two bits
//               cleared) and err_alineacion is tied to 0.
//
// Parameters:
//   RESET_PC       PC loaded on reset (must be a multiple of 4)
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   rst_n          asynchronous active-low reset
//   Direccion      byte address to instruction memory (= PC register)
//   B1..B4         memory bytes at Direccion+0..+3, B1 most significant
//   instr          registered instruction word {B1,B2,B3,B4}
//   pc_instr       address the word in instr was fetched from
//   valid          instr/pc_instr hold a word for decode
//   ready          decode accepts the word this cycle
//   salto          branch redirect request (single-cycle pulse)
//   dest_salto     branch target byte address
//   detenido       fetch halted
//   err_alineacion sticky misaligned-branch flag
// ---------------------------------------------------------------------------
module unidad_fetch #(
    parameter logic [6:0] RESET_PC = 7'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [6:0]  Direccion,
    input  logic [7:0]  B1,
    input  logic [7:0]  B2,
    input  logic [7:0]  B3,
    input  logic [7:0]  B4,
    output logic [31:0] instr,
    output logic [6:0]  pc_instr,
    output logic        valid,
    input  logic        ready,
    input  logic        salto,
    input  logic [6:0]  dest_salto,
    output logic        detenido,
    output logic        err_alineacion
);

    typedef enum logic [1:0] {
        ARRANQUE = 2'd0,
        ACTIVO   = 2'd1,
        DETENIDO = 2'd2
    } estado_t;

    localparam logic [31:0] PALABRA_ALTO = 32'hFFFF_FFFF;

    estado_t     estado_q, estado_d;
    logic [6:0]  pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [6:0]  pc_instr_q, pc_instr_d;
    logic        valid_q, valid_d;
    logic        detenido_q, detenido_d;
`ifdef FETCH_ALINEACION_EN
    logic        err_q, err_d;
`endif

    logic [31:0] palabra;
    logic        captura_ok;

    assign palabra    = {B1, B2, B3, B4};
    // A new word may be taken when the output slot is empty or being drained.
    assign captura_ok = (estado_q == ACTIVO) && (!valid_q || ready);

    always_comb begin
        estado_d   = estado_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        pc_instr_d = pc_instr_q;
        valid_d    = valid_q;
        detenido_d = detenido_q;
`ifdef FETCH_ALINEACION_EN
        err_d      = err_q;
`endif
        case (estado_q)
            ARRANQUE: begin
                // One dead cycle after reset; branches are ignored here.
                valid_d  = 1'b0;
                estado_d = ACTIVO;
            end
            ACTIVO: begin
                if (salto) begin
                    // A redirect always discards the held word, even if decode
                    // would have accepted it this cycle.
                    valid_d = 1'b0;
`ifdef FETCH_ALINEACION_EN
                    if (dest_salto[1:0] != 2'b00) begin
                        err_d      = 1'b1;
                        estado_d   = DETENIDO;
                        detenido_d = 1'b1;
                    end else begin
                        pc_d = dest_salto;
                    end
`else
                    pc_d = dest_salto & 7'h7C;
`endif
                end else if (captura_ok) begin
                    if (palabra == PALABRA_ALTO) begin
                        // Halt word is never delivered; PC stays pointing at it.
                        valid_d    = 1'b0;
                        estado_d   = DETENIDO;
                        detenido_d = 1'b1;
                    end else begin
                        instr_d    = palabra;
                        pc_instr_d = pc_q;
                        valid_d    = 1'b1;
                        pc_d       = pc_q + 7'd4; // wraps modulo 128
                    end
                end
            end
            DETENIDO: begin
                valid_d = 1'b0;
            end
            default: begin
                estado_d = ARRANQUE;
                valid_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q   <= ARRANQUE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'h0;
            pc_instr_q <= 7'h0;
            valid_q    <= 1'b0;
            detenido_q <= 1'b0;
`ifdef FETCH_ALINEACION_EN
            err_q      <= 1'b0;
`endif
        end else begin
            estado_q   <= estado_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            pc_instr_q <= pc_instr_d;
            valid_q    <= valid_d;
            detenido_q <= detenido_d;
`ifdef FETCH_ALINEACION_EN
            err_q      <= err_d;
`endif
        end
    end

    assign Direccion = pc_q;
    assign instr     = instr_q;
    assign pc_instr  = pc_instr_q;
    assign valid     = valid_q;
    assign detenido  = detenido_q;
`ifdef FETCH_ALINEACION_EN
    assign err_alineacion = err_q;
`else
    assign err_alineacion = 1'b0;
`endif

endmodule

// File: tb/tb_unidad_fetch.sv
// ---------------------------------------------------------------------------
// tb_unidad_fetch
//
// Self-checking bench for unidad_fetch. A 128-byte memory array feeds the
// DUT. A transaction-level reference model (boot cycle, PC, held word, halt
// and error flags) predicts every output after each rising edge. Directed
// sequences cover streaming, backpressure, branch flush, wrap-around, halt
// and misaligned branches, followed by a randomized phase.
// Honors FETCH_ALINEACION_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_unidad_fetch;

    logic        clk;
    logic        rst_n;
    logic [6:0]  Direccion;
    logic [7:0]  B1, B2, B3, B4;
    logic [31:0] instr;
    logic [6:0]  pc_instr;
    logic        valid;
    logic        ready;
    logic        salto;
    logic [6:0]  dest_salto;
    logic        detenido;
    logic        err_alineacion;

    logic [7:0]  mem [128];
    logic [6:0]  a1, a2, a3;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit          m_booted;
    bit          m_halted;
    bit          m_valid;
    bit          m_err;
    logic [6:0]  m_pc;
    logic [6:0]  m_pcin;
    logic [31:0] m_instr;

    unidad_fetch #(.RESET_PC(7'd0)) dut (
        .clk(clk), .rst_n(rst_n), .Direccion(Direccion),
        .B1(B1), .B2(B2), .B3(B3), .B4(B4),
        .instr(instr), .pc_instr(pc_instr), .valid(valid), .ready(ready),
        .salto(salto), .dest_salto(dest_salto),
        .detenido(detenido), .err_alineacion(err_alineacion)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a1 = Direccion + 7'd1;
    assign a2 = Direccion + 7'd2;
    assign a3 = Direccion + 7'd3;
    assign B1 = mem[Direccion];
    assign B2 = mem[a1];
    assign B3 = mem[a2];
    assign B4 = mem[a3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [6:0] a);
        logic [6:0] p;
        logic [31:0] w;
        w = 32'h0;
        for (int k = 0; k < 4; k++) begin
            p = a + 7'(k);
            w = {w[23:0], mem[p]};
        end
        return w;
    endfunction

    function automatic bit misaligned_halts(input logic [6:0] d);
`ifdef FETCH_ALINEACION_EN
        return (d % 4) != 0;
`else
        return 1'b0 && (d != 0);
`endif
    endfunction

    task automatic model_reset();
        m_booted = 0; m_halted = 0; m_valid = 0; m_err = 0;
        m_pc = 7'd0; m_pcin = 7'd0; m_instr = 32'h0;
    endtask

    // One clock edge of the fetch stage, expressed as transactions.
    task automatic model_edge(input bit s, input logic [6:0] d, input bit r);
        logic [31:0] w;
        if (!m_booted) begin
            m_booted = 1;
        end else if (m_halted) begin
            m_valid = 0;
        end else if (s) begin
            m_valid = 0;
            if (misaligned_halts(d)) begin
                m_err = 1; m_halted = 1;
            end else begin
                m_pc = 7'((int'(d) / 4) * 4);
            end
        end else if (!m_valid || r) begin
            w = mem_word(m_pc);
            if (w == 32'hFFFF_FFFF) begin
                m_halted = 1; m_valid = 0;
            end else begin
                m_instr = w; m_pcin = m_pc; m_valid = 1;
                m_pc = 7'((int'(m_pc) + 4) % 128);
            end
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".valid"},     {31'h0, valid},          {31'h0, m_valid});
        check({tag, ".instr"},     instr,                   m_instr);
        check({tag, ".pc_instr"},  {25'h0, pc_instr},       {25'h0, m_pcin});
        check({tag, ".Direccion"}, {25'h0, Direccion},      {25'h0, m_pc});
        check({tag, ".detenido"},  {31'h0, detenido},       {31'h0, m_halted});
        check({tag, ".err"},       {31'h0, err_alineacion}, {31'h0, m_err});
    endtask

    task automatic cycle(input string tag, input bit s, input logic [6:0] d, input bit r);
        salto = s; dest_salto = d; ready = r;
        @(posedge clk);
        model_edge(s, d, r);
        #1;
        salto = 1'b0;
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; ready = 1'b0; salto = 1'b0; dest_salto = 7'd0;
        for (int i = 0; i < 128; i++) mem[i] = 8'(i);
        model_reset();

        // streaming
        do_reset();
        cycle("boot", 1'b1, 7'd20, 1'b1);   // salto ignored during boot
        cycle("first", 1'b0, 7'd0, 1'b1);
        check("first_word", instr, 32'h00010203);
        cycle("stream1", 1'b0, 7'd0, 1'b1);
        check("second_word", instr, 32'h04050607);
        cycle("stream2", 1'b0, 7'd0, 1'b1);
        check("third_word", instr, 32'h08090A0B);

        // backpressure
        for (int i = 0; i < 3; i++) cycle("stall", 1'b0, 7'd0, 1'b0);
        check("stall_pc", {25'h0, pc_instr}, 32'd8);
        cycle("release", 1'b0, 7'd0, 1'b1);
        check("release_pc", {25'h0, pc_instr}, 32'd12);

        // branch flush
        cycle("branch", 1'b1, 7'd40, 1'b1);
        check("branch_flush", {31'h0, valid}, 32'd0);
        cycle("branch_tgt", 1'b0, 7'd0, 1'b1);
        check("branch_word", instr, 32'h28292A2B);
        cycle("branch_next", 1'b0, 7'd0, 1'b1);

        // wrap-around
        cycle("to120", 1'b1, 7'd120, 1'b1);
        for (int i = 0; i < 3; i++) cycle("wrap", 1'b0, 7'd0, 1'b1);
        check("wrap_pc", {25'h0, pc_instr}, 32'd0);

        // misaligned branch
        cycle("misal", 1'b1, 7'd42, 1'b1);
        cycle("misal_next", 1'b0, 7'd0, 1'b1);
`ifdef FETCH_ALINEACION_EN
        check("misal_err", {31'h0, err_alineacion}, 32'd1);
`else
        check("misal_pc", {25'h0, pc_instr}, 32'd40);
`endif

        // halt at address 8
        for (int i = 8; i < 12; i++) mem[i] = 8'hFF;
        do_reset();
        for (int i = 0; i < 5; i++) cycle("halt", 1'b0, 7'd0, 1'b1);
        check("halt_det", {31'h0, detenido}, 32'd1);
        check("halt_addr", {25'h0, Direccion}, 32'd8);
        cycle("halt_salto", 1'b1, 7'd40, 1'b1);
        cycle("halt_hold", 1'b0, 7'd0, 1'b1);
        do_reset();
        check("halt_cleared", {31'h0, detenido}, 32'd0);

        // randomized phase
        for (int blk = 0; blk < 12; blk++) begin
            for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
            if ($urandom_range(0, 1) == 1) begin
                int w;
                w = $urandom_range(0, 31) * 4;
                for (int k = 0; k < 4; k++) mem[w + k] = 8'hFF;
            end
            do_reset();
            for (int i = 0; i < 50; i++) begin
                cycle("rand", ($urandom_range(0, 9) == 0),
                      7'($urandom_range(0, 127)), ($urandom_range(0, 3) != 0));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
